// File: rtl/csr_trap_unit.sv
// csr_trap_unit
// Executes CSR instructions (CSRRW/RS/RC and immediate forms) and sequences
// synchronous traps (ecall, ebreak, illegal) and mret.
// Every access goes through the CSR register file's one read port and one
// write port. Each step of an instruction takes its own cycle, so every
// write is committed before any later read.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid / ex_ready   handshake with the execute stage (ready only when idle)
//   ex_pc, ex_instr       PC and raw instruction word of the offered instruction
//   ex_is_csr, ex_is_ecall, ex_is_ebreak, ex_is_mret, ex_illegal   decode flags
//   ex_funct3, ex_csr_addr, ex_rs1_idx, ex_rs1_val                 CSR operands
//   csr_rd_val / csr_rd_valid      old CSR value and rd writeback strobe
//   redirect_valid / redirect_pc   pipeline flush and new fetch target
//   csr_addr_r, csr_data_r         register file read port (combinational read)
//   csr_mtvec                      mtvec tap from the register file
//   csr_addr_w, csr_data_w, csr_we register file write port

module csr_trap_unit #(
   parameter int CAUSE_ILLEGAL = 2,
   parameter int CAUSE_EBREAK  = 3,
   parameter int CAUSE_ECALL   = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_instr,
   input  logic        ex_is_csr,
   input  logic        ex_is_ecall,
   input  logic        ex_is_ebreak,
   input  logic        ex_is_mret,
   input  logic        ex_illegal,
   input  logic [2:0]  ex_funct3,
   input  logic [11:0] ex_csr_addr,
   input  logic [4:0]  ex_rs1_idx,
   input  logic [31:0] ex_rs1_val,
   output logic [31:0] csr_rd_val,
   output logic        csr_rd_valid,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [11:0] csr_addr_r,
   input  logic [31:0] csr_data_r,
   input  logic [31:0] csr_mtvec,
   output logic [11:0] csr_addr_w,
   output logic [31:0] csr_data_w,
   output logic        csr_we
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;

   typedef enum logic [3:0] {
      IDLE, CSR_RD, CSR_WR, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_EPC, M_STAT
   } state_t;

   typedef enum logic [1:0] {
      TRAP_ILLEGAL, TRAP_EBREAK, TRAP_ECALL
   } trap_t;

   state_t      state_q, state_d;
   trap_t       trap_q, trap_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [11:0] addr_q, addr_d;
   logic [4:0]  rs1_idx_q, rs1_idx_d;
   logic [31:0] rs1_val_q, rs1_val_d;
   logic [31:0] old_q, old_d;
   logic [31:0] epc_q, epc_d;

   logic [31:0] operand;
   logic [31:0] csr_wr_data;
   logic [31:0] cause_val;
   logic [31:0] tval_val;
   logic [31:0] trap_mstatus;
   logic [31:0] mret_mstatus;
   logic        unused_mtvec_mode;

   // Only direct-mode mtvec is supported, so the mode bits are ignored.
   assign unused_mtvec_mode = ^csr_mtvec[1:0];

   assign ex_ready = (state_q == IDLE);

   // funct3 bit 2 selects the zimm form, where rs1_idx itself is the operand.
   assign operand = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_val_q;

   // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
   assign trap_mstatus = {csr_data_r[31:13], 2'b11, csr_data_r[10:8], csr_data_r[3],
                          csr_data_r[6:4], 1'b0, csr_data_r[2:0]};

   // mret: MIE <= MPIE, MPIE <= 1, MPP stays M.
   assign mret_mstatus = {csr_data_r[31:13], 2'b11, csr_data_r[10:8], 1'b1,
                          csr_data_r[6:4], csr_data_r[7], csr_data_r[2:0]};

   // Read-modify-write data for the CSR instruction, based on the latched old value.
   always_comb begin
      csr_wr_data = operand;
      case (funct3_q[1:0])
         2'b10:   csr_wr_data = old_q | operand;
         2'b11:   csr_wr_data = old_q & ~operand;
         default: csr_wr_data = operand;
      endcase
   end

   // Trap cause and mtval depend only on the trap kind captured at dispatch.
   always_comb begin
      cause_val = 32'(CAUSE_ILLEGAL);
      tval_val  = instr_q;
      case (trap_q)
         TRAP_EBREAK: begin
            cause_val = 32'(CAUSE_EBREAK);
            tval_val  = pc_q;
         end
         TRAP_ECALL: begin
            cause_val = 32'(CAUSE_ECALL);
            tval_val  = 32'h0;
         end
         default: begin
            cause_val = 32'(CAUSE_ILLEGAL);
            tval_val  = instr_q;
         end
      endcase
   end

   // Next-state logic. Operands are captured only when an instruction is
   // accepted in IDLE; while busy the ex_* inputs are ignored. A CSR op with
   // funct3 000 or 100 is reserved and dispatched as an illegal instruction.
   always_comb begin
      state_d   = state_q;
      trap_d    = trap_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      funct3_d  = funct3_q;
      addr_d    = addr_q;
      rs1_idx_d = rs1_idx_q;
      rs1_val_d = rs1_val_q;
      old_d     = old_q;
      epc_d     = epc_q;
      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               pc_d      = ex_pc;
               instr_d   = ex_instr;
               funct3_d  = ex_funct3;
               addr_d    = ex_csr_addr;
               rs1_idx_d = ex_rs1_idx;
               rs1_val_d = ex_rs1_val;
               if (ex_illegal) begin
                  trap_d  = TRAP_ILLEGAL;
                  state_d = T_EPC;
               end else if (ex_is_ecall) begin
                  trap_d  = TRAP_ECALL;
                  state_d = T_EPC;
               end else if (ex_is_ebreak) begin
                  trap_d  = TRAP_EBREAK;
                  state_d = T_EPC;
               end else if (ex_is_mret) begin
                  state_d = M_EPC;
               end else if (ex_is_csr) begin
                  if (ex_funct3[1:0] == 2'b00) begin
                     trap_d  = TRAP_ILLEGAL;
                     state_d = T_EPC;
                  end else begin
                     state_d = CSR_RD;
                  end
               end
            end
         end
         CSR_RD: begin
            old_d   = csr_data_r;
            state_d = CSR_WR;
         end
         CSR_WR:  state_d = IDLE;
         T_EPC:   state_d = T_CAUSE;
         T_CAUSE: state_d = T_TVAL;
         T_TVAL:  state_d = T_STAT;
         T_STAT:  state_d = IDLE;
         M_EPC: begin
            epc_d   = csr_data_r;
            state_d = M_STAT;
         end
         M_STAT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and captured registers; reset aborts any sequence in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         trap_q    <= TRAP_ILLEGAL;
         pc_q      <= 32'h0;
         instr_q   <= 32'h0;
         funct3_q  <= 3'h0;
         addr_q    <= 12'h0;
         rs1_idx_q <= 5'h0;
         rs1_val_q <= 32'h0;
         old_q     <= 32'h0;
         epc_q     <= 32'h0;
      end else begin
         state_q   <= state_d;
         trap_q    <= trap_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         rs1_idx_q <= rs1_idx_d;
         rs1_val_q <= rs1_val_d;
         old_q     <= old_d;
         epc_q     <= epc_d;
      end
   end

   // Port decode: a pure function of the current state and captured
   // registers, so nothing on ex_* reaches the register file ports. The only
   // data taken from the read port in the same cycle is the old mstatus
   // during its read-modify-write. RS/RC with rs1 = x0 must not write.
   always_comb begin
      csr_addr_r     = 12'h0;
      csr_addr_w     = 12'h0;
      csr_data_w     = 32'h0;
      csr_we         = 1'b0;
      csr_rd_val     = 32'h0;
      csr_rd_valid   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      case (state_q)
         CSR_RD: csr_addr_r = addr_q;
         CSR_WR: begin
            csr_addr_w   = addr_q;
            csr_data_w   = csr_wr_data;
            csr_we       = !(funct3_q[1] && (rs1_idx_q == 5'd0));
            csr_rd_val   = old_q;
            csr_rd_valid = 1'b1;
         end
         T_EPC: begin
            csr_addr_w = ADDR_MEPC;
            csr_data_w = pc_q & ~32'h3;
            csr_we     = 1'b1;
         end
         T_CAUSE: begin
            csr_addr_w = ADDR_MCAUSE;
            csr_data_w = cause_val;
            csr_we     = 1'b1;
         end
         T_TVAL: begin
            csr_addr_w = ADDR_MTVAL;
            csr_data_w = tval_val;
            csr_we     = 1'b1;
         end
         T_STAT: begin
            csr_addr_r     = ADDR_MSTATUS;
            csr_addr_w     = ADDR_MSTATUS;
            csr_data_w     = trap_mstatus;
            csr_we         = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = {csr_mtvec[31:2], 2'b00};
         end
         M_EPC: csr_addr_r = ADDR_MEPC;
         M_STAT: begin
            csr_addr_r     = ADDR_MSTATUS;
            csr_addr_w     = ADDR_MSTATUS;
            csr_data_w     = mret_mstatus;
            csr_we         = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit
// Directed bench for csr_trap_unit. A small CSR register file lives in the
// bench. Each step pushes the writes, rd strobes and redirects it expects,
// together with their cycle offset from the accept edge. A monitor pops the
// entries as the DUT produces them and compares them.

module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_instr;
   logic        ex_is_csr, ex_is_ecall, ex_is_ebreak, ex_is_mret, ex_illegal;
   logic [2:0]  ex_funct3;
   logic [11:0] ex_csr_addr;
   logic [4:0]  ex_rs1_idx;
   logic [31:0] ex_rs1_val;
   logic [31:0] csr_rd_val;
   logic        csr_rd_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [11:0] csr_addr_r;
   logic [31:0] csr_data_r;
   logic [31:0] csr_mtvec;
   logic [11:0] csr_addr_w;
   logic [31:0] csr_data_w;
   logic        csr_we;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      int          off;
   } exp_t;

   exp_t wr_q[$];
   exp_t rd_q[$];
   exp_t rdir_q[$];
   exp_t mon_exp;
   int   mon_off;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int accept_cyc = 0;

   logic [31:0] regs [0:4095];
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;

   csr_trap_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_pc          (ex_pc),
      .ex_instr       (ex_instr),
      .ex_is_csr      (ex_is_csr),
      .ex_is_ecall    (ex_is_ecall),
      .ex_is_ebreak   (ex_is_ebreak),
      .ex_is_mret     (ex_is_mret),
      .ex_illegal     (ex_illegal),
      .ex_funct3      (ex_funct3),
      .ex_csr_addr    (ex_csr_addr),
      .ex_rs1_idx     (ex_rs1_idx),
      .ex_rs1_val     (ex_rs1_val),
      .csr_rd_val     (csr_rd_val),
      .csr_rd_valid   (csr_rd_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .csr_addr_r     (csr_addr_r),
      .csr_data_r     (csr_data_r),
      .csr_mtvec      (csr_mtvec),
      .csr_addr_w     (csr_addr_w),
      .csr_data_w     (csr_data_w),
      .csr_we         (csr_we)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp DUT events relative to the accept edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Bench-side CSR register file: combinational read, write on the clock
   // edge; the bench preloads values through a side port while the DUT idles.
   assign csr_data_r = regs[csr_addr_r];
   assign csr_mtvec  = regs[12'h305];

   always @(posedge clk) begin
      if (csr_we)
         regs[csr_addr_w] <= csr_data_w;
      else if (pre_en)
         regs[pre_addr] <= pre_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic pushWr(input logic [11:0] addr, input logic [31:0] data, input int off);
      wr_q.push_back('{addr, data, off});
   endtask

   task automatic pushRd(input logic [31:0] data, input int off);
      rd_q.push_back('{12'h0, data, off});
   endtask

   task automatic pushRedirect(input logic [31:0] pc, input int off);
      rdir_q.push_back('{12'h0, pc, off});
   endtask

   task automatic preload(input logic [11:0] addr, input logic [31:0] data);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = addr;
      pre_data = data;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   // Offers one instruction when the unit is idle and returns just after the
   // accept edge, which becomes the reference for cycle offsets.
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                input logic is_csr, input logic is_ecall,
                                input logic is_ebreak, input logic is_mret,
                                input logic illegal, input logic [2:0] funct3,
                                input logic [11:0] addr, input logic [4:0] idx,
                                input logic [31:0] val);
      @(negedge clk);
      checkOutput("ready_before_accept", 32'(ex_ready), 32'd1);
      ex_valid     = 1'b1;
      ex_pc        = pc;
      ex_instr     = instr;
      ex_is_csr    = is_csr;
      ex_is_ecall  = is_ecall;
      ex_is_ebreak = is_ebreak;
      ex_is_mret   = is_mret;
      ex_illegal   = illegal;
      ex_funct3    = funct3;
      ex_csr_addr  = addr;
      ex_rs1_idx   = idx;
      ex_rs1_val   = val;
      @(posedge clk);
      #1;
      accept_cyc   = cyc;
      ex_valid     = 1'b0;
      ex_is_csr    = 1'b0;
      ex_is_ecall  = 1'b0;
      ex_is_ebreak = 1'b0;
      ex_is_mret   = 1'b0;
      ex_illegal   = 1'b0;
   endtask

   // Waits (bounded) for ex_ready to return and checks the cycle it did.
   task automatic waitReady(input string tag, input int exp_off);
      int off;
      off = 99;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ex_ready) begin
            off = cyc - accept_cyc + 1;
            break;
         end
      end
      checkOutput(tag, 32'(off), 32'(exp_off));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"},     32'(ex_ready), 32'd1);
      checkOutput({tag, "_we"},        32'(csr_we), 32'd0);
      checkOutput({tag, "_rd_valid"},  32'(csr_rd_valid), 32'd0);
      checkOutput({tag, "_redirect"},  32'(redirect_valid), 32'd0);
      checkOutput({tag, "_addr_r"},    {20'b0, csr_addr_r}, 32'd0);
      checkOutput({tag, "_addr_w"},    {20'b0, csr_addr_w}, 32'd0);
      checkOutput({tag, "_data_w"},    csr_data_w, 32'd0);
      checkOutput({tag, "_rd_val"},    csr_rd_val, 32'd0);
      checkOutput({tag, "_redir_pc"},  redirect_pc, 32'd0);
   endtask

   // Scoreboard monitor: every write, rd strobe and redirect must match the
   // oldest pending expectation, including its cycle offset.
   always @(negedge clk) begin
      if (rst_n) begin
         mon_off = cyc - accept_cyc + 1;
         if (csr_we) begin
            checkOutput("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               mon_exp = wr_q.pop_front();
               checkOutput("wr_addr", {20'b0, csr_addr_w}, {20'b0, mon_exp.addr});
               checkOutput("wr_data", csr_data_w, mon_exp.data);
               checkOutput("wr_cycle", 32'(mon_off), 32'(mon_exp.off));
            end
         end
         if (csr_rd_valid) begin
            checkOutput("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
               mon_exp = rd_q.pop_front();
               checkOutput("rd_val", csr_rd_val, mon_exp.data);
               checkOutput("rd_cycle", 32'(mon_off), 32'(mon_exp.off));
            end
         end
         if (redirect_valid) begin
            checkOutput("redirect_expected", 32'(rdir_q.size() != 0), 32'd1);
            if (rdir_q.size() != 0) begin
               mon_exp = rdir_q.pop_front();
               checkOutput("redirect_pc", redirect_pc, mon_exp.data);
               checkOutput("redirect_cycle", 32'(mon_off), 32'(mon_exp.off));
            end
         end
      end
   end

   // Directed sequence.
   initial begin
      rst_n        = 1'b0;
      ex_valid     = 1'b0;
      ex_pc        = 32'h0;
      ex_instr     = 32'h0;
      ex_is_csr    = 1'b0;
      ex_is_ecall  = 1'b0;
      ex_is_ebreak = 1'b0;
      ex_is_mret   = 1'b0;
      ex_illegal   = 1'b0;
      ex_funct3    = 3'h0;
      ex_csr_addr  = 12'h0;
      ex_rs1_idx   = 5'h0;
      ex_rs1_val   = 32'h0;
      pre_en       = 1'b0;
      pre_addr     = 12'h0;
      pre_data     = 32'h0;

      preload(12'h340, 32'h1234_5678);
      preload(12'h300, 32'h0000_0008);
      preload(12'h304, 32'h0000_000F);
      preload(12'h305, 32'h8000_0101);
      preload(12'h341, 32'h0000_0000);
      @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(ex_ready), 32'd1);

      $display("[TB] CSRRW mscratch");
      pushWr(12'h340, 32'hDEAD_BEEF, 2);
      pushRd(32'h1234_5678, 2);
      applyStimulus(32'h8000_0000, 32'h3400_9073, 1, 0, 0, 0, 0, 3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF);
      @(negedge clk);
      checkOutput("csrrw_addr_r", {20'b0, csr_addr_r}, 32'h340);
      checkOutput("csrrw_busy", 32'(ex_ready), 32'd0);
      waitReady("csrrw_ready_cycle", 3);
      checkOutput("mscratch_after", regs[12'h340], 32'hDEAD_BEEF);

      $display("[TB] CSRRS mstatus with rs1 = x0");
      pushRd(32'h0000_0008, 2);
      applyStimulus(32'h8000_0004, 32'h3000_2073, 1, 0, 0, 0, 0, 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF);
      waitReady("csrrs_ready_cycle", 3);
      checkOutput("mstatus_unchanged", regs[12'h300], 32'h0000_0008);

      $display("[TB] CSRRCI mie");
      pushWr(12'h304, 32'h0000_000A, 2);
      pushRd(32'h0000_000F, 2);
      applyStimulus(32'h8000_0008, 32'h3042_F073, 1, 0, 0, 0, 0, 3'b111, 12'h304, 5'd5, 32'hFFFF_FFFF);
      waitReady("csrrci_ready_cycle", 3);
      checkOutput("mie_after", regs[12'h304], 32'h0000_000A);

      $display("[TB] ecall");
      pushWr(12'h341, 32'h8000_0044, 1);
      pushWr(12'h342, 32'd11, 2);
      pushWr(12'h343, 32'h0, 3);
      pushWr(12'h300, 32'h0000_1880, 4);
      pushRedirect(32'h8000_0100, 4);
      applyStimulus(32'h8000_0046, 32'h0000_0073, 0, 1, 0, 0, 0, 3'b000, 12'h000, 5'd0, 32'h0);
      waitReady("ecall_ready_cycle", 5);

      $display("[TB] mret");
      preload(12'h341, 32'h8000_0048);
      pushWr(12'h300, 32'h0000_1888, 2);
      pushRedirect(32'h8000_0048, 2);
      applyStimulus(32'h8000_0100, 32'h3020_0073, 0, 0, 0, 1, 0, 3'b000, 12'h000, 5'd0, 32'h0);
      waitReady("mret_ready_cycle", 3);

      $display("[TB] ebreak");
      pushWr(12'h341, 32'h0000_0100, 1);
      pushWr(12'h342, 32'd3, 2);
      pushWr(12'h343, 32'h0000_0100, 3);
      pushWr(12'h300, 32'h0000_1880, 4);
      pushRedirect(32'h8000_0100, 4);
      applyStimulus(32'h0000_0100, 32'h0010_0073, 0, 0, 1, 0, 0, 3'b000, 12'h000, 5'd0, 32'h0);
      waitReady("ebreak_ready_cycle", 5);

      $display("[TB] CSR op with reserved funct3");
      pushWr(12'h341, 32'h0000_0204, 1);
      pushWr(12'h342, 32'd2, 2);
      pushWr(12'h343, 32'h3400_0073, 3);
      pushWr(12'h300, 32'h0000_1800, 4);
      pushRedirect(32'h8000_0100, 4);
      applyStimulus(32'h0000_0206, 32'h3400_0073, 1, 0, 0, 0, 0, 3'b100, 12'h340, 5'd1, 32'h5555_5555);
      waitReady("reserved_ready_cycle", 5);

      $display("[TB] no decode flag");
      applyStimulus(32'h0000_0300, 32'h0000_0013, 0, 0, 0, 0, 0, 3'b001, 12'h340, 5'd1, 32'h1);
      @(negedge clk);
      checkOutput("noflag_ready", 32'(ex_ready), 32'd1);
      checkOutput("mscratch_untouched", regs[12'h340], 32'hDEAD_BEEF);

      $display("[TB] illegal+ecall with reset in the middle");
      pushWr(12'h341, 32'h0000_0300, 1);
      pushWr(12'h342, 32'd2, 2);
      applyStimulus(32'h0000_0300, 32'hFFFF_FFFF, 0, 1, 0, 0, 1, 3'b000, 12'h000, 5'd0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      checkResetOutputs("midreset_held");
      rst_n = 1'b1;
      @(negedge clk);
      checkResetOutputs("after_midreset");

      checkOutput("wr_q_drained", 32'(wr_q.size()), 32'd0);
      checkOutput("rd_q_drained", 32'(rd_q.size()), 32'd0);
      checkOutput("redirect_q_drained", 32'(rdir_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends even if a wait were to stall.
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

CSR-instruction executor and synchronous-trap sequencer sitting between the execute stage and the machine-mode CSR register file. It serialises every CSR access onto the register file's single read port and single write port. It executes CSRRW/CSRRS/CSRRC and their immediate variants, and sequences the mepc/mcause/mtval/mstatus updates for ecall, ebreak and illegal instructions. It also executes mret and issues a PC redirect with flush to the fetch stage.

## Interface
Parameters:
- CAUSE_ILLEGAL, default 2, mcause value for illegal instruction.
- CAUSE_EBREAK, default 3, mcause value for ebreak.
- CAUSE_ECALL, default 11, mcause value for ecall from M-mode.

Ports:
- clk  in  1  clock; reset rst_n, asynchronous, active-low.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  unit idle; instruction accepted when ex_valid && ex_ready.
- ex_pc  in  32  PC of the instruction.
- ex_instr  in  32  raw instruction word, used for mtval.
- ex_is_csr / ex_is_ecall / ex_is_ebreak / ex_is_mret / ex_illegal  in  1 each  decode flags.
- ex_funct3  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101/110/111 immediate forms.
- ex_csr_addr  in  12  CSR address.
- ex_rs1_idx  in  5  rs1 index, which is also zimm.
- ex_rs1_val  in  32  rs1 value.
- csr_rd_val  out  32  old CSR value for rd.
- csr_rd_valid  out  1  one-cycle pulse; rd writeback strobe.
- redirect_valid  out  1  one-cycle pulse; flush the pipeline and fetch from redirect_pc.
- redirect_pc  out  32  target PC.
- csr_addr_r  out  12  register file read address.
- csr_data_r  in  32  register file read data (combinational).
- csr_mtvec  in  32  register file mtvec tap.
- csr_addr_w  out  12  register file write address.
- csr_data_w  out  32  register file write data.
- csr_we  out  1  register file write enable.

## Operation
- States: IDLE, CSR_RD, CSR_WR, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_EPC, M_STAT.
- ex_ready = 1 only in IDLE.
- On accept, capture pc, instr, funct3, addr, rs1_idx and rs1_val into internal registers.
- Dispatch priority when several flags are set: illegal > ecall > ebreak > mret > csr.
- funct3 of 000 or 100 with ex_is_csr is treated as illegal.
- No flag set on accept: consumed silently and the unit stays in IDLE.
- Operand: register forms use rs1_val; immediate forms use {27'b0, rs1_idx}.
- CSR_RD:
  - csr_addr_r = addr_q.
  - Latch csr_data_r into old_q.
  - Next state CSR_WR.
- CSR_WR:
  - csr_addr_w = addr_q.
  - Write data: RW writes operand; RS writes old_q | operand; RC writes old_q & ~operand.
  - csr_we = 1, except RS/RC with rs1_idx == 0, which write nothing.
  - csr_rd_val = old_q and csr_rd_valid = 1.
  - Next state IDLE.
- Trap path:
  - T_EPC: write mepc (0x341) = pc_q & ~3.
  - T_CAUSE: write mcause (0x342) = cause.
  - T_TVAL: write mtval (0x343) = instr_q for illegal, pc_q for ebreak, 0 for ecall.
  - T_STAT: read and write mstatus (0x300) in the same cycle. New value: old with bit 7 = old bit 3, bit 3 = 0, bits 12:11 = 11.
  - T_STAT also pulses redirect_valid with redirect_pc = {csr_mtvec[31:2], 2'b00}; direct mode only.
  - Next state IDLE.
- mret path:
  - M_EPC: csr_addr_r = 0x341; latch the value into epc_q.
  - M_STAT: read-modify-write mstatus with bit 3 = old bit 7, bit 7 = 1, bits 12:11 = 11.
  - M_STAT pulses redirect with redirect_pc = epc_q.
  - Next state IDLE.
- All register-file-side outputs are Moore functions of state and captured registers; there is no combinational path from ex_* to the CSR ports.
- Strict serialisation means every write is committed before any later read. No bypass is needed.

## Timing
- Reset: state IDLE; ex_ready = 1; csr_we, csr_rd_valid and redirect_valid = 0; all address, data and PC outputs = 0.
- Reset asserted mid-sequence aborts immediately. Writes already committed remain; the register file is reset alongside this unit.
- CSR instruction accepted at edge T:
  - CSR_RD during cycle T+1.
  - Write and csr_rd_valid during cycle T+2.
  - ex_ready again at T+3.
- Trap accepted at T: writes in cycles T+1 to T+4 in the order mepc, mcause, mtval, mstatus. redirect_valid is high in T+4 and ex_ready in T+5.
- mret accepted at T: redirect_valid in T+2 and ex_ready in T+3.
- csr_we is high for exactly one cycle per write. Writes to the same address are never issued in consecutive cycles.
- While busy, ex_ready = 0. Upstream holds its inputs, and they are ignored.

## Test plan
- CSRRW on 0x340 with rs1_val = 0xDEADBEEF, mscratch previously 0x12345678 -> csr_rd_val = 0x12345678 at T+2; mscratch reads 0xDEADBEEF afterwards.
- CSRRS on 0x300 with rs1_idx = 0 -> csr_we stays 0 throughout; csr_rd_valid pulses with the current mstatus.
- CSRRCI on 0x304 with zimm = 5 and mie = 0xF -> mie = 0xA.
- mtvec = 0x80000101 and mstatus = 0x8, then ecall at pc 0x80000046 -> mepc = 0x80000044, mcause = 11, mtval = 0, mstatus = 0x1880, redirect_pc = 0x80000100 at T+4.
- mret afterwards with mepc = 0x80000048 and mstatus = 0x1880 -> redirect_pc = 0x80000048 at T+2; mstatus = 0x1888.
- Illegal with instr 0xFFFFFFFF and ecall both set, with rst_n pulsed low in T_CAUSE -> mcause = 2 (illegal wins). After reset all outputs = 0, state IDLE, ex_ready = 1.
